// File: rtl/sam_tx_if.sv
// sam_tx_if -- bundles the configuration inputs, the payload handshake and
// the serial line outputs of sam_tx.
//
// Handshake: a payload byte is transferred on a rising clk edge where
// msg_valid and msg_ready are both high. msg_ready is combinational and
// may drop in the same cycle cfg_start rises. The master must hold
// msg_data stable while msg_valid is high and not yet accepted.
//
// Signals:
//   cfg_start, cfg_n[3:0], cfg_d[7:0], cfg_N[7:0]  configuration request and values
//   msg_data[7:0], msg_valid, msg_ready            payload byte handshake
//   str, mode, frame, configured                   serial line and status
//   fsm_state[1:0]                                 debug view of the transmitter FSM
interface sam_tx_if;
  logic       cfg_start;
  logic [3:0] cfg_n;
  logic [7:0] cfg_d;
  logic [7:0] cfg_N;
  logic [7:0] msg_data;
  logic       msg_valid;
  logic       msg_ready;
  logic       str;
  logic       mode;
  logic       frame;
  logic       configured;
  logic [1:0] fsm_state;

  modport slave (
    input  cfg_start, cfg_n, cfg_d, cfg_N, msg_data, msg_valid,
    output msg_ready, str, mode, frame, configured, fsm_state
  );

  modport master (
    output cfg_start, cfg_n, cfg_d, cfg_N, msg_data, msg_valid,
    input  msg_ready, str, mode, frame, configured, fsm_state
  );
endinterface

// File: rtl/sam_tx.sv
// sam_tx -- serial transmitter. First sends a 20-bit configuration word
// {n, d, N} MSB first with mode=1, then sends payload frames: NB bits of
// each accepted byte (MSB of the NB-bit field first), each bit held for SPB
// cycles with frame=1, followed by N idle gap cycles.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    sam_tx_if.slave (configuration, payload handshake, serial outputs,
//          FSM debug state)
module sam_tx (
  input  logic     clk,
  input  logic     reset,
  sam_tx_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CFG  = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t      state, state_next;

  logic [3:0]  lat_n, lat_n_next;
  logic [7:0]  lat_d, lat_d_next;
  logic [7:0]  lat_gap, lat_gap_next;
  logic [7:0]  data_q, data_next;
  logic [5:0]  cnt_sample, cnt_sample_next;
  logic [3:0]  cnt_bit, cnt_bit_next;
  logic [7:0]  cnt_gap, cnt_gap_next;
  logic        str_q, str_next;
  logic        mode_q, mode_next;
  logic        frame_q, frame_next;
  logic        configured_q, configured_next;

  logic [19:0] cfg_word;
  logic [3:0]  nb;
  logic [5:0]  spb;
  logic [2:0]  first_idx;
  logic [2:0]  next_bit_idx;
  logic [4:0]  cfg_idx;
  logic        ready;
  logic        accept_cfg;
  logic        accept_msg;

  assign cfg_word = {lat_n, lat_d, lat_gap};

  // Clamp the latched frame parameters into their legal ranges.
  always_comb begin
    nb = lat_n;
    if (lat_n == 4'd0)     nb = 4'd1;
    else if (lat_n > 4'd8) nb = 4'd8;

    spb = lat_d[5:0];
    if (lat_d < 8'd10)      spb = 6'd10;
    else if (lat_d > 8'd60) spb = 6'd60;
  end

  assign first_idx    = 3'(nb - 4'd1);
  assign next_bit_idx = 3'(cnt_bit - 4'd1);
  // Index of the configuration bit to present in the following cycle.
  assign cfg_idx      = 5'(5'd18 - cnt_sample[4:0]);

  assign ready      = (state == IDLE) && configured_q && !bus.cfg_start;
  assign accept_cfg = (state == IDLE) && bus.cfg_start;
  assign accept_msg = bus.msg_valid && ready;

  // Next-state and next-output logic. Outputs are registered, so each
  // branch computes what str/mode/frame must show during the next cycle.
  always_comb begin
    state_next      = state;
    lat_n_next      = lat_n;
    lat_d_next      = lat_d;
    lat_gap_next    = lat_gap;
    data_next       = data_q;
    cnt_sample_next = cnt_sample;
    cnt_bit_next    = cnt_bit;
    cnt_gap_next    = cnt_gap;
    configured_next = configured_q;
    str_next        = 1'b0;
    mode_next       = 1'b0;
    frame_next      = 1'b0;

    case (state)
      IDLE: begin
        if (accept_cfg) begin
          state_next      = CFG;
          lat_n_next      = bus.cfg_n;
          lat_d_next      = bus.cfg_d;
          lat_gap_next    = bus.cfg_N;
          cnt_sample_next = 6'd0;
          mode_next       = 1'b1;
          str_next        = bus.cfg_n[3];
        end else if (accept_msg) begin
          state_next      = DATA;
          data_next       = bus.msg_data;
          cnt_bit_next    = nb - 4'd1;
          cnt_sample_next = 6'd0;
          frame_next      = 1'b1;
          str_next        = bus.msg_data[first_idx];
        end
      end

      CFG: begin
        // cnt_sample counts the configuration bits 0..19 here.
        if (cnt_sample == 6'd19) begin
          state_next      = IDLE;
          configured_next = 1'b1;
        end else begin
          cnt_sample_next = cnt_sample + 6'd1;
          mode_next       = 1'b1;
          str_next        = cfg_word[cfg_idx];
        end
      end

      DATA: begin
        if (cnt_sample == spb - 6'd1) begin
          if (cnt_bit == 4'd0) begin
            cnt_gap_next = 8'd0;
            state_next   = (lat_gap == 8'd0) ? IDLE : GAP;
          end else begin
            cnt_bit_next    = cnt_bit - 4'd1;
            cnt_sample_next = 6'd0;
            frame_next      = 1'b1;
            str_next        = data_q[next_bit_idx];
          end
        end else begin
          cnt_sample_next = cnt_sample + 6'd1;
          frame_next      = 1'b1;
          str_next        = str_q;
        end
      end

      GAP: begin
        if (cnt_gap == lat_gap - 8'd1) state_next = IDLE;
        else                           cnt_gap_next = cnt_gap + 8'd1;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      lat_n        <= 4'd0;
      lat_d        <= 8'd0;
      lat_gap      <= 8'd0;
      data_q       <= 8'd0;
      cnt_sample   <= 6'd0;
      cnt_bit      <= 4'd0;
      cnt_gap      <= 8'd0;
      str_q        <= 1'b0;
      mode_q       <= 1'b0;
      frame_q      <= 1'b0;
      configured_q <= 1'b0;
    end else begin
      state        <= state_next;
      lat_n        <= lat_n_next;
      lat_d        <= lat_d_next;
      lat_gap      <= lat_gap_next;
      data_q       <= data_next;
      cnt_sample   <= cnt_sample_next;
      cnt_bit      <= cnt_bit_next;
      cnt_gap      <= cnt_gap_next;
      str_q        <= str_next;
      mode_q       <= mode_next;
      frame_q      <= frame_next;
      configured_q <= configured_next;
    end
  end

  assign bus.msg_ready  = ready;
  assign bus.str        = str_q;
  assign bus.mode       = mode_q;
  assign bus.frame      = frame_q;
  assign bus.configured = configured_q;
  assign bus.fsm_state  = state;

endmodule

// File: tb/tb_sam_tx.sv
// tb_sam_tx -- self-checking bench for sam_tx. The reference model expands
// each configuration or message into the per-cycle expected values of
// {str, mode, frame, msg_ready}, which are drained cycle by cycle.
module tb_sam_tx;

  logic clk = 1'b0;
  logic reset;

  sam_tx_if bus();

  sam_tx dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_err = 0;

  // Expected {str, mode, frame, msg_ready} per cycle.
  logic [3:0] exp_q[$];

  // Reference model state
  int m_n, m_d, m_gap;
  bit m_cfg;

  function automatic int nb_of(int n);
    if (n < 1) return 1;
    if (n > 8) return 8;
    return n;
  endfunction

  function automatic int spb_of(int d);
    if (d < 10) return 10;
    if (d > 60) return 60;
    return d;
  endfunction

  task automatic idle_inputs();
    bus.cfg_start = 1'b0;
    bus.msg_valid = 1'b0;
  endtask

  // Model: a configuration shows its 20-bit word with mode=1, then idle.
  task automatic push_cfg(input int n, input int d, input int gap);
    logic [19:0] w;
    w = {4'(n), 8'(d), 8'(gap)};
    for (int i = 19; i >= 0; i--) exp_q.push_back({w[i], 1'b1, 1'b0, 1'b0});
    exp_q.push_back(4'b0001);
  endtask

  // Model: NB payload bits of SPB cycles, N gap cycles, then idle.
  task automatic push_msg(input logic [7:0] b);
    int nb, spb;
    nb  = nb_of(m_n);
    spb = spb_of(m_d);
    for (int i = nb - 1; i >= 0; i--)
      for (int s = 0; s < spb; s++) exp_q.push_back({b[i], 1'b0, 1'b1, 1'b0});
    for (int g = 0; g < m_gap; g++) exp_q.push_back(4'b0000);
    exp_q.push_back(4'b0001);
  endtask

  // Scoreboard: drains up to max_elems expected cycles. While the DUT is
  // busy the inputs are randomised, which must have no effect.
  task automatic run_scoreboard(input string name, input int max_elems);
    logic [3:0] got, exp;
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < max_elems) begin
      if (exp_q.size() > 1) begin
        bus.cfg_start = 1'($urandom_range(0, 1));
        bus.msg_valid = 1'($urandom_range(0, 1));
        bus.msg_data  = 8'($urandom);
        bus.cfg_n     = 4'($urandom);
        bus.cfg_d     = 8'($urandom);
        bus.cfg_N     = 8'($urandom);
      end else begin
        idle_inputs();
      end
      #1;
      exp = exp_q.pop_front();
      got = {bus.str, bus.mode, bus.frame, bus.msg_ready};
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL %s cycle %0d: str/mode/frame/ready got %b expected %b", name, k, got, exp);
      end
      k++;
      @(negedge clk);
    end
  endtask

  // Driver: request a configuration (optionally with msg_valid also high).
  task automatic do_config(input int n, input int d, input int gap, input bit with_valid,
                           input string name, input int limit);
    bus.cfg_start = 1'b1;
    bus.cfg_n     = 4'(n);
    bus.cfg_d     = 8'(d);
    bus.cfg_N     = 8'(gap);
    bus.msg_valid = with_valid;
    bus.msg_data  = 8'($urandom);
    #1;
    n_cmp++;
    if (bus.msg_ready !== 1'b0) begin
      n_err++;
      $display("FAIL %s_req_ready: got %b expected 0", name, bus.msg_ready);
    end
    @(negedge clk);
    m_n   = n & 15;
    m_d   = d & 255;
    m_gap = gap & 255;
    push_cfg(m_n, m_d, m_gap);
    run_scoreboard(name, limit);
    if (exp_q.size() == 0) m_cfg = 1'b1;
  endtask

  // Driver: offer one payload byte in IDLE.
  task automatic send_msg(input logic [7:0] b, input string name, input int limit);
    bus.cfg_start = 1'b0;
    bus.msg_valid = 1'b1;
    bus.msg_data  = b;
    #1;
    n_cmp++;
    if (bus.msg_ready !== m_cfg) begin
      n_err++;
      $display("FAIL %s_ready: got %b expected %b", name, bus.msg_ready, m_cfg);
    end
    @(negedge clk);
    if (m_cfg) push_msg(b);
    run_scoreboard(name, limit);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    bus.cfg_n = 4'd0; bus.cfg_d = 8'd0; bus.cfg_N = 8'd0; bus.msg_data = 8'd0;
    m_cfg = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({bus.str, bus.mode, bus.frame, bus.configured, bus.msg_ready} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {bus.str, bus.mode, bus.frame, bus.configured, bus.msg_ready});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_unconfigured(input string name);
    for (int i = 0; i < 5; i++) begin
      bus.msg_valid = 1'b1;
      bus.msg_data  = 8'($urandom);
      #1;
      n_cmp++;
      if ({bus.msg_ready, bus.frame, bus.str, bus.configured} !== 4'b0) begin
        n_err++;
        $display("FAIL %s cycle %0d: ready/frame/str/configured got %b expected 0000",
                 name, i, {bus.msg_ready, bus.frame, bus.str, bus.configured});
      end
      @(negedge clk);
    end
    bus.msg_valid = 1'b0;
  endtask

  task automatic test_config();
    do_config(8, 12, 3, 1'b0, "cfg_8_12_3", 1000000);
    n_cmp++;
    if (bus.configured !== 1'b1) begin
      n_err++;
      $display("FAIL configured_flag: got %b expected 1", bus.configured);
    end
  endtask

  task automatic test_frame();
    send_msg(8'hA5, "frame_a5", 1000000);
  endtask

  task automatic test_clamp();
    do_config(12, 5, 0, 1'b0, "clamp_hi_cfg", 1000000);
    send_msg(8'($urandom), "clamp_hi_msg", 1000000);
    do_config(0, 200, $urandom_range(0, 4), 1'b0, "clamp_lo_cfg", 1000000);
    send_msg(8'($urandom), "clamp_lo_msg", 1000000);
  endtask

  task automatic test_priority();
    // Both requests together: configuration wins, message stays unconsumed.
    do_config(8, 10, 2, 1'b1, "priority_cfg", 1000000);
    send_msg(8'h3C, "priority_msg", 1000000);
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 6; c++) begin
      do_config($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 40),
                1'b0, "rand_cfg", 1000000);
      for (int m = 0; m < 2; m++) send_msg(8'($urandom), "rand_msg", 1000000);
    end
  endtask

  // Assert reset asynchronously between edges, check outputs clear at once,
  // then check that no message is accepted before reconfiguration.
  task automatic pulse_reset(input string name);
    exp_q.delete();
    idle_inputs();
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.str, bus.mode, bus.frame, bus.configured, bus.msg_ready} !== 5'b0) begin
      n_err++;
      $display("FAIL %s_async: got %b expected 00000", name,
               {bus.str, bus.mode, bus.frame, bus.configured, bus.msg_ready});
    end
    @(negedge clk);
    reset = 1'b0;
    m_cfg = 1'b0;
    test_unconfigured({name, "_after"});
  endtask

  task automatic test_reset_mid();
    // Mid-DATA, inside bit 3 of an 8-bit, 12-sample frame.
    do_config(8, 12, 3, 1'b0, "rmid_cfg", 1000000);
    send_msg(8'hC3, "rmid_data", 3 * 12 + 5);
    pulse_reset("rst_data");
    // Mid-CFG.
    do_config(8, 12, 3, 1'b0, "rmid_cfg_part", 9);
    pulse_reset("rst_cfg");
    // Mid-GAP.
    do_config(2, 10, 30, 1'b0, "rmid_gcfg", 1000000);
    send_msg(8'h02, "rmid_gap", 2 * 10 + 7);
    pulse_reset("rst_gap");
    // Recovery.
    do_config(5, 15, 4, 1'b0, "recover_cfg", 1000000);
    send_msg(8'($urandom), "recover_msg", 1000000);
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_unconfigured("unconfigured");
    test_config();
    test_frame();
    test_clamp();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
